// File: rtl/elastic_buf_write_ctrl.sv
// RX elastic buffer write side: binary/Gray write pointer, full detection, overflow flag.
// Optional SKP removal under high occupancy is enabled by defining EB_SKP_DROP_EN.
module elastic_buf_write_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int PTR_WIDTH  = 4,
  parameter int HIGH_WM    = 6,
  parameter int MAX_DROP   = 1
) (
  input  logic                  recovered_clk,
  input  logic                  recovered_rst,
  input  logic                  rx_valid,
  input  logic                  rx_skp,
  input  logic                  higher_gen_en,
  input  logic                  LTSSM_rst,
  input  logic [PTR_WIDTH-1:0]  w_gray_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0]  gray_wptr,
  output logic                  full,
  output logic                  skp_dropped,
  output logic                  overflow
);

  localparam logic [PTR_WIDTH-1:0] HIGH_WM_P = PTR_WIDTH'(HIGH_WM);

  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [PTR_WIDTH-1:0]  gray_q, gray_d;
  logic                  overflow_q;
  logic [PTR_WIDTH-1:0]  rptr_bin;
  logic [PTR_WIDTH-1:0]  occupancy;
  logic                  accept;
  logic                  drop;
  logic                  high_occ;

  always_comb begin
    rptr_bin = '0;
    rptr_bin[PTR_WIDTH-1] = w_gray_rptr[PTR_WIDTH-1];
    for (int i = PTR_WIDTH-2; i >= 0; i--) begin
      rptr_bin[i] = rptr_bin[i+1] ^ w_gray_rptr[i];
    end
  end

  assign occupancy = wptr_q - rptr_bin;
  assign high_occ  = (occupancy >= HIGH_WM_P);
  // Two MSBs inverted in Gray space means the pointers are exactly one lap apart.
  assign full      = (gray_q == {~w_gray_rptr[PTR_WIDTH-1:PTR_WIDTH-2], w_gray_rptr[PTR_WIDTH-3:0]});
  assign accept    = rx_valid & higher_gen_en & ~LTSSM_rst;
  assign wen       = accept & ~drop & ~full;
  assign wptr_d    = wptr_q + PTR_WIDTH'(1);
  assign gray_d    = wptr_d ^ (wptr_d >> 1);

  always_ff @(posedge recovered_clk or negedge recovered_rst) begin
    if (!recovered_rst) begin
      wptr_q     <= '0;
      waddr_q    <= '0;
      gray_q     <= '0;
      overflow_q <= 1'b0;
    end else if (LTSSM_rst) begin
      wptr_q     <= '0;
      waddr_q    <= '0;
      gray_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wen) begin
        wptr_q  <= wptr_d;
        waddr_q <= wptr_d[ADDR_WIDTH-1:0];
        gray_q  <= gray_d;
      end
      if (accept && !drop && full) overflow_q <= 1'b1;
    end
  end

  assign waddr     = waddr_q;
  assign gray_wptr = gray_q;
  assign overflow  = overflow_q;

`ifdef EB_SKP_DROP_EN
  typedef enum logic {DATA, SKP_RUN} state_t;
  localparam logic [1:0] MAX_DROP_P = 2'(MAX_DROP);

  state_t     state_q;
  logic [1:0] drop_cnt_q;
  logic [1:0] run_cnt;
  logic       skp_dropped_q;

  // A fresh run always starts from zero regardless of what the counter holds.
  assign run_cnt = (state_q == DATA) ? 2'd0 : drop_cnt_q;
  assign drop    = accept & rx_skp & high_occ & (run_cnt < MAX_DROP_P);

  always_ff @(posedge recovered_clk or negedge recovered_rst) begin
    if (!recovered_rst) begin
      state_q       <= DATA;
      drop_cnt_q    <= 2'd0;
      skp_dropped_q <= 1'b0;
    end else if (LTSSM_rst) begin
      state_q       <= DATA;
      drop_cnt_q    <= 2'd0;
      skp_dropped_q <= 1'b0;
    end else begin
      skp_dropped_q <= drop;
      if (accept) begin
        case (state_q)
          DATA: begin
            if (rx_skp) begin
              state_q    <= SKP_RUN;
              drop_cnt_q <= {1'b0, drop};
            end
          end
          SKP_RUN: begin
            if (!rx_skp) begin
              state_q    <= DATA;
              drop_cnt_q <= 2'd0;
            end else if (drop && drop_cnt_q != MAX_DROP_P) begin
              drop_cnt_q <= drop_cnt_q + 2'd1;
            end
          end
          default: begin
            state_q    <= DATA;
            drop_cnt_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign skp_dropped = skp_dropped_q;
`else
  logic unused_skp;
  assign unused_skp  = rx_skp ^ high_occ;
  assign drop        = 1'b0;
  assign skp_dropped = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_buf_write_ctrl.sv
// Directed bench for elastic_buf_write_ctrl; SKP-drop cases follow EB_SKP_DROP_EN.
module tb_elastic_buf_write_ctrl;

  logic       recovered_clk = 1'b0;
  logic       recovered_rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_skp = 1'b0;
  logic       higher_gen_en = 1'b1;
  logic       LTSSM_rst = 1'b0;
  logic [3:0] w_gray_rptr = 4'd0;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] gray_wptr;
  logic       full;
  logic       skp_dropped;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  elastic_buf_write_ctrl #(
    .ADDR_WIDTH(3), .PTR_WIDTH(4), .HIGH_WM(6), .MAX_DROP(1)
  ) dut (
    .recovered_clk(recovered_clk),
    .recovered_rst(recovered_rst),
    .rx_valid(rx_valid),
    .rx_skp(rx_skp),
    .higher_gen_en(higher_gen_en),
    .LTSSM_rst(LTSSM_rst),
    .w_gray_rptr(w_gray_rptr),
    .wen(wen),
    .waddr(waddr),
    .gray_wptr(gray_wptr),
    .full(full),
    .skp_dropped(skp_dropped),
    .overflow(overflow)
  );

  always #5 recovered_clk = ~recovered_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic tick();
    @(posedge recovered_clk);
    #1;
  endtask

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic clear_ltssm();
    rx_valid  = 1'b0;
    rx_skp    = 1'b0;
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
  endtask

  // Push n plain entries with w_gray_rptr fixed.
  task automatic push_data(input int n);
    rx_valid = 1'b1;
    rx_skp   = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] rptr;

    #3;
    chk("rst_waddr", waddr, 3'd0);
    chk("rst_gray", gray_wptr, 4'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_skpd", skp_dropped, 1'b0);
    #9 recovered_rst = 1'b1;
    tick();

    // Fill all 8 entries against a stationary read pointer.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_waddr", waddr, 32'(i));
      chk("fill_wen", wen, 1'b1);
      tick();
    end
    rx_valid = 1'b0;
    #1;
    chk("fill_gray", gray_wptr, 4'b1100);
    chk("fill_full", full, 1'b1);
    chk("fill_ovf0", overflow, 1'b0);
    rx_valid = 1'b1;
    #1;
    chk("ninth_wen", wen, 1'b0);
    tick();
    rx_valid = 1'b0;
    chk("ninth_ovf", overflow, 1'b1);
    chk("ninth_gray", gray_wptr, 4'b1100);

    // Synchronous clear overrides a concurrent entry.
    rx_valid  = 1'b1;
    LTSSM_rst = 1'b1;
    #1;
    chk("ltssm_wen", wen, 1'b0);
    tick();
    LTSSM_rst = 1'b0;
    rx_valid  = 1'b0;
    chk("ltssm_gray", gray_wptr, 4'd0);
    chk("ltssm_waddr", waddr, 3'd0);
    chk("ltssm_ovf", overflow, 1'b0);
    chk("ltssm_full", full, 1'b0);

    // Wrap with the read pointer trailing by two.
    prev_gray = gray_wptr;
    for (int k = 0; k < 20; k++) begin
      rptr        = (k >= 2) ? 4'(k - 2) : 4'd0;
      w_gray_rptr = bin2gray(rptr);
      rx_valid    = 1'b1;
      #1;
      chk("wrap_full", full, 1'b0);
      chk("wrap_wen", wen, 1'b1);
      tick();
      chk("wrap_1bit", $countones(gray_wptr ^ prev_gray), 1);
      chk("wrap_gray", gray_wptr, bin2gray(4'(k + 1)));
      prev_gray = gray_wptr;
    end
    rx_valid = 1'b0;
    chk("wrap_waddr", waddr, 3'd4);

    // Disabled block discards input without flagging overflow.
    higher_gen_en = 1'b0;
    rx_valid      = 1'b1;
    #1;
    chk("dis_wen", wen, 1'b0);
    tick();
    rx_valid = 1'b0;
    higher_gen_en = 1'b1;
    chk("dis_waddr", waddr, 3'd4);
    chk("dis_ovf", overflow, 1'b0);

    w_gray_rptr = 4'd0;
    clear_ltssm();

`ifdef EB_SKP_DROP_EN
    // Occupancy 6: first SKP of the run dropped, the rest written.
    push_data(6);
    rx_valid = 1'b1;
    rx_skp   = 1'b1;
    #1;
    chk("drop_wen0", wen, 1'b0);
    tick();
    chk("drop_pulse", skp_dropped, 1'b1);
    chk("drop_waddr0", waddr, 3'd6);
    chk("drop_wen1", wen, 1'b1);
    tick();
    chk("drop_pulse1", skp_dropped, 1'b0);
    chk("drop_wen2", wen, 1'b1);
    tick();
    rx_valid = 1'b0;
    rx_skp   = 1'b0;
    chk("drop_gray", gray_wptr, 4'b1100);
    chk("drop_full", full, 1'b1);
    chk("drop_ovf", overflow, 1'b0);

    // Occupancy 5: SKP written; data ends the run; a new run can drop again.
    clear_ltssm();
    push_data(5);
    rx_valid = 1'b1;
    rx_skp   = 1'b1;
    #1;
    chk("low_wen", wen, 1'b1);
    tick();
    chk("low_skpd", skp_dropped, 1'b0);
    rx_skp = 1'b0;
    tick();
    rx_skp = 1'b1;
    #1;
    chk("rerun_wen", wen, 1'b0);
    tick();
    rx_valid = 1'b0;
    rx_skp   = 1'b0;
    chk("rerun_pulse", skp_dropped, 1'b1);
    chk("rerun_waddr", waddr, 3'd7);
`else
    // Without SKP removal a SKP at occupancy 7 is written like data.
    push_data(7);
    rx_valid = 1'b1;
    rx_skp   = 1'b1;
    #1;
    chk("nodrop_wen", wen, 1'b1);
    tick();
    rx_valid = 1'b0;
    rx_skp   = 1'b0;
    chk("nodrop_skpd", skp_dropped, 1'b0);
    chk("nodrop_gray", gray_wptr, 4'b1100);
    chk("nodrop_full", full, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
